// File: rtl/spgd_pkg.sv
// Shared SPGD control definitions: measurement-sequencer state encoding and
// default datapath widths.
package spgd_pkg;

    localparam int FP_WIDTH_DEF = 64;
    localparam int SEQ_STATE_W  = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/spgd_down_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero and holds there
// until the next load.
module spgd_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spgd_meas_seq.sv
// SPGD measurement sequencer: settle delay, 2^LOG2_AVG ADC conversions,
// truncated mean out as one J value, sticky timeout flag.
//
// state  | meaning
// IDLE   | waiting for meas_req
// SETTLE | DAC settle delay, settle_cyc cycles
// CONV   | single-cycle adc_en trigger
// WAIT   | waiting for adc_done, bounded by TIMEOUT_CYC
// DONE   | register the mean; j_valid follows next cycle
module spgd_meas_seq
    import spgd_pkg::*;
#(
    parameter int FP_WIDTH    = FP_WIDTH_DEF,
    parameter int LOG2_AVG    = 3,
    parameter int SETTLE_W    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   adc_clk,
    input  logic                   rst_n,
    input  logic                   meas_req,
    input  logic                   abort,
    input  logic [SETTLE_W-1:0]    settle_cyc,
    input  logic                   adc_done,
    input  logic [FP_WIDTH-1:0]    adc_in,
    output logic                   adc_en,
    output logic [FP_WIDTH-1:0]    j_out,
    output logic                   j_valid,
    output logic                   busy,
    output logic                   err,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    localparam int ACC_W = FP_WIDTH + LOG2_AVG;
    localparam int SMP_W = LOG2_AVG + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = (SETTLE_W > TO_W) ? SETTLE_W : TO_W;

    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((1 << LOG2_AVG) - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t        state, state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [SMP_W-1:0]  smp_cnt;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              acc_clr, acc_add, err_set, err_clr, j_load;

    // Counter is loaded with N-1 so the zero flag marks the last cycle of the phase.
    spgd_down_cnt #(.W(CNT_W)) u_cnt (
        .clk      (adc_clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        j_load    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (meas_req) begin
                    acc_clr  = 1'b1;
                    err_clr  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(settle_cyc) - CNT_W'(1);
                    state_nxt = (settle_cyc == '0) ? ST_CONV : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) state_nxt = ST_CONV;
            end
            ST_CONV: begin
                cnt_load  = 1'b1;
                cnt_val   = TO_LOAD;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_done) begin
                    acc_add   = 1'b1;
                    state_nxt = (smp_cnt == LAST_SMP) ? ST_DONE : ST_CONV;
                end else if (cnt_zero) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                j_load    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort wins over everything; outputs and err stay as they are.
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b0;
            acc_add   = 1'b0;
            err_set   = 1'b0;
            err_clr   = 1'b0;
            j_load    = 1'b0;
            acc_clr   = 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            adc_en  <= 1'b0;
            busy    <= 1'b0;
            j_out   <= '0;
            j_valid <= 1'b0;
            err     <= 1'b0;
            acc     <= '0;
            smp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            adc_en  <= (state_nxt == ST_CONV);
            busy    <= (state_nxt != ST_IDLE);
            j_valid <= j_load;
            if (j_load) j_out <= FP_WIDTH'(acc >> LOG2_AVG);
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (acc_clr) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (acc_add) begin
                acc     <= acc + ACC_W'(adc_in);
                smp_cnt <= smp_cnt + SMP_W'(1);
            end
        end
    end

    assign seq_state = state;

endmodule
